activation_stream_unit: RTL
===========================

ACTIVATION_STREAM_UNIT -- requirements
Module: activation_stream_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: signed two's-complement element width.
REQ-002 SHALL have parameter LANES, default 4: elements processed per beat.
REQ-003 SHALL have parameter NUM_ELEMENTS, default 16: elements per tensor; must be a multiple of LANES; BEATS = NUM_ELEMENTS/LANES.
REQ-004 SHALL have parameter LEAKY_SHIFT, default 3: arithmetic right-shift amount for the leaky slope.
REQ-005 SHALL use clock clk; reset rst, asynchronous, active-high.
REQ-006 SHALL have port clk, input, 1 bit: clock.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-008 SHALL have port start, input, 1 bit: single-cycle tensor start pulse.
REQ-009 SHALL have port mode, input, 2 bits: 0 identity, 1 ReLU, 2 leaky ReLU, 3 clipped ReLU.
REQ-010 SHALL have port clip_max, input, DATA_WIDTH bits: signed upper bound for mode 3.
REQ-011 SHALL have port busy, output, 1 bit: high in RUN.
REQ-012 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_data (input, LANES*DATA_WIDTH): input stream, lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-014 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, LANES*DATA_WIDTH), out_last (output, 1): output stream.

Function
REQ-015 SHALL implement FSM IDLE->RUN on start; RUN->DONE when the final output beat is accepted (out_valid&&out_ready&&out_last); DONE->IDLE unconditionally after one cycle.
REQ-016 SHALL latch mode and clip_max on the cycle start is accepted in IDLE; changes during RUN SHALL be ignored.
REQ-017 SHALL ignore start in RUN and DONE.
REQ-018 SHALL drive in_ready = (state==RUN) && (in_count<BEATS) && (!out_valid || out_ready).
REQ-019 SHALL transfer a beat when in_valid&&in_ready and present its result on out_data with out_valid high on the next cycle (latency 1).
REQ-020 SHALL hold out_data, out_valid and out_last stable while out_valid&&!out_ready.
REQ-021 SHALL sustain one beat per cycle when in_valid and out_ready are continuously high.
REQ-022 SHALL assert out_last with the output beat derived from input beat BEATS-1.
REQ-023 Mode 0 SHALL output x; mode 1 SHALL output x if x>=0, else 0; mode 2 SHALL output x if x>=0, else x>>>LEAKY_SHIFT; mode 3 SHALL output 0 if x<0, clip_max if x>clip_max, else x.
REQ-024 In mode 3, a negative latched clip_max SHALL be treated as 0.
REQ-025 All arithmetic SHALL be signed DATA_WIDTH with no widening; results can never overflow.
REQ-026 SHALL pulse done in the DONE state only; busy SHALL equal (state==RUN).
REQ-027 SHALL clear in_count and out_count on entry to IDLE.

Reset
REQ-028 On rst, SHALL return to IDLE with busy, done, in_ready, out_valid and out_last at 0, out_data at 0, and counters at 0, including during an in-progress RUN; the partial tensor SHALL be discarded.

Configuration
REQ-029 With macro ACT_SPARSITY_EN defined, SHALL add output zero_count, width $clog2(NUM_ELEMENTS+1), counting zero-valued output elements of the current tensor; it is valid while done is high, cleared at start and on reset.
REQ-030 With ACT_SPARSITY_EN undefined, SHALL have no zero_count port and no counter logic.

Structure
REQ-031 A shared package act_pkg SHALL hold mode encodings (ACT_IDENTITY, ACT_RELU, ACT_LEAKY, ACT_CLIP) and the FSM state type.
REQ-032 Per-element math SHALL be one sub-module act_lane, instantiated LANES times.

Verification
REQ-033 DW=8, LANES=4, N=16, mode 1, input beats {-5,3,0,-128}: outputs {0,3,0,0}, out_last on beat 4, done one cycle after the last accept.
REQ-034 Mode 2, LEAKY_SHIFT=3, inputs {-16,-1,-128,7}: outputs {-2,-1,-16,7}.
REQ-035 Mode 3, clip_max=6, inputs {10,6,-3,127}: outputs {6,6,0,6}; with clip_max=-4, input 5 yields 0.
REQ-036 out_ready low for 3 cycles mid-tensor: out_data held stable, in_ready low, no beat lost or duplicated, 4 beats total.
REQ-037 rst asserted after beat 2 of a tensor: all outputs 0 next cycle, FSM in IDLE; a new start processes a full 4-beat tensor correctly.
REQ-038 ACT_SPARSITY_EN defined, mode 1, tensor with 9 non-positive elements: zero_count=9 while done is high.

Source files
------------

// File: rtl/act_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | act_pkg                                                                    |
// | Shared mode encodings and FSM state type for the activation stream unit.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package act_pkg;

  localparam logic [1:0] ACT_IDENTITY = 2'd0;
  localparam logic [1:0] ACT_RELU     = 2'd1;
  localparam logic [1:0] ACT_LEAKY    = 2'd2;
  localparam logic [1:0] ACT_CLIP     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } act_state_t;

endpackage : act_pkg
`default_nettype wire

// File: rtl/act_lane.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | act_lane                                                                   |
// | Combinational per-element activation (identity/ReLU/leaky/clipped ReLU).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module act_lane
  import act_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic [1:0]                   mode,
  input  logic signed [DATA_WIDTH-1:0] clip_max,
  input  logic signed [DATA_WIDTH-1:0] x,
  output logic signed [DATA_WIDTH-1:0] y
);

  logic signed [DATA_WIDTH-1:0] clip_lim;
  logic                         x_neg;

  always_comb begin
    // A negative ceiling collapses the clip window to zero.
    clip_lim = clip_max[DATA_WIDTH-1] ? '0 : clip_max;
    x_neg    = x[DATA_WIDTH-1];
    y        = x;
    case (mode)
      ACT_IDENTITY: y = x;
      ACT_RELU: begin
        if (x_neg) y = '0;
      end
      ACT_LEAKY: begin
        if (x_neg) y = x >>> LEAKY_SHIFT;
      end
      ACT_CLIP: begin
        if (x_neg)              y = '0;
        else if (x > clip_lim)  y = clip_lim;
      end
      default: y = x;
    endcase
  end

endmodule : act_lane
`default_nettype wire

// File: rtl/activation_stream_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | activation_stream_unit                                                     |
// | Streams a tensor through per-lane activations with 1-cycle latency.        |
// | Optional macro ACT_SPARSITY_EN adds a zero-element counter (zero_count).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module activation_stream_unit
  import act_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int LANES        = 4,
  parameter int NUM_ELEMENTS = 16,
  parameter int LEAKY_SHIFT  = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [1:0]                  mode,
  input  logic [DATA_WIDTH-1:0]       clip_max,
  output logic                        busy,
  output logic                        done,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic                        out_last
`ifdef ACT_SPARSITY_EN
  ,
  output logic [$clog2(NUM_ELEMENTS+1)-1:0] zero_count
`endif
);

  localparam int             BEATS  = NUM_ELEMENTS / LANES;
  localparam int             CW     = $clog2(BEATS + 1);
  localparam logic [CW-1:0]  BEATS_C = CW'(BEATS);
  localparam logic [CW-1:0]  LAST_C  = CW'(BEATS - 1);

  act_state_t                  state_q, state_d;
  logic [CW-1:0]               in_count_q, in_count_d;
  logic [CW-1:0]               out_count_q, out_count_d;
  logic [1:0]                  mode_q, mode_d;
  logic [DATA_WIDTH-1:0]       clip_q, clip_d;
  logic                        out_valid_q, out_valid_d;
  logic [LANES*DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [LANES*DATA_WIDTH-1:0] lane_data;
  logic                        in_fire;
  logic                        out_fire;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      act_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .LEAKY_SHIFT(LEAKY_SHIFT)
      ) u_lane (
        .mode    (mode_q),
        .clip_max(clip_q),
        .x       (in_data[gi*DATA_WIDTH +: DATA_WIDTH]),
        .y       (lane_data[gi*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  // The last beat is recognised by its position, so it stays stable during a stall.
  assign out_last  = out_valid_q && (out_count_q == LAST_C);
  assign in_ready  = (state_q == ST_RUN) && (in_count_q < BEATS_C)
                     && (!out_valid_q || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    in_count_d  = in_count_q;
    out_count_d = out_count_q;
    mode_d      = mode_q;
    clip_d      = clip_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (in_fire) begin
      out_valid_d = 1'b1;
      out_data_d  = lane_data;
      in_count_d  = in_count_q + CW'(1);
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
    if (out_fire) out_count_d = out_count_q + CW'(1);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          mode_d      = mode;
          clip_d      = clip_max;
          in_count_d  = '0;
          out_count_d = '0;
        end
      end
      ST_RUN: begin
        if (out_fire && out_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        in_count_d  = '0;
        out_count_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_count_q  <= '0;
      out_count_q <= '0;
      mode_q      <= ACT_IDENTITY;
      clip_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      in_count_q  <= in_count_d;
      out_count_q <= out_count_d;
      mode_q      <= mode_d;
      clip_q      <= clip_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef ACT_SPARSITY_EN
  localparam int ZW = $clog2(NUM_ELEMENTS + 1);

  logic [ZW-1:0] zero_count_q, zero_count_d;

  always_comb begin
    zero_count_d = zero_count_q;
    if (state_q == ST_IDLE && start) begin
      zero_count_d = '0;
    end else if (in_fire) begin
      for (int i = 0; i < LANES; i++) begin
        zero_count_d = zero_count_d
                       + ZW'(lane_data[i*DATA_WIDTH +: DATA_WIDTH] == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) zero_count_q <= '0;
    else     zero_count_q <= zero_count_d;
  end

  assign zero_count = zero_count_q;
`endif

endmodule : activation_stream_unit
`default_nettype wire
